// File: rtl/column_stream_source.sv
// column_stream_source
//   Fetches one angular slice (both half-panel columns) from the slice-image
//   BRAM per theta_tick, assembles it into column_data and offers it to the
//   HUB75 column driver on a valid/ready handshake. Also owns the theta
//   (rotational position) counter, re-zeroed by the hall-sensor index pulse.
//
//   Optional build macro: COLUMN_SRC_TEST_PATTERN_EN
//     defined   -> pixels are (fetch_theta + half*NUM_ROWS + row) mod 2**RGB_RES,
//                  bram_data ignored, identical timing
//     undefined -> pixels come from bram_data
//
// Ports
//   clk_in, rst_in     clock, synchronous active-high reset
//   theta_tick         advance to next slice (1-cycle pulse)
//   index_in           hall index; next fetch is slice 0
//   bram_addr          read address, holds outside FETCH
//   bram_data          read data, BRAM_LATENCY cycles behind bram_addr
//   column_data        [half][row] pixel words
//   theta              slice of current / most recent column_data
//   tvalid, tready     output handshake
//   missed_tick        sticky: a tick was dropped
module column_stream_source #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int NUM_ROWS       = 64,
    parameter int RGB_RES        = 9,
    parameter int BRAM_LATENCY   = 2
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        theta_tick,
    input  logic                                        index_in,
    output logic [$clog2(ROTATIONAL_RES*2*NUM_ROWS)-1:0] bram_addr,
    input  logic [RGB_RES-1:0]                          bram_data,
    output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]       column_data,
    output logic [$clog2(ROTATIONAL_RES)-1:0]           theta,
    output logic                                        tvalid,
    input  logic                                        tready,
    output logic                                        missed_tick
);
    localparam int ADDR_W = $clog2(ROTATIONAL_RES*2*NUM_ROWS);
    localparam int TH_W   = $clog2(ROTATIONAL_RES);
    localparam int IDX_W  = $clog2(2*NUM_ROWS);
    localparam int DR_W   = $clog2(BRAM_LATENCY+1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;
    state_t state, state_nxt;

    logic [TH_W-1:0]   theta_cnt;
    logic [TH_W-1:0]   theta_inc;
    logic              pending;
    logic [IDX_W-1:0]  fetch_cnt;
    logic [DR_W-1:0]   drain_cnt;
    logic [ADDR_W-1:0] base_addr;
    logic [RGB_RES-1:0] pix;

    // Index travels alongside the address so each return lands in its slot;
    // stage 0 is aligned with bram_addr, stage BRAM_LATENCY with bram_data.
    logic [BRAM_LATENCY:0]            vld_pipe;
    logic [BRAM_LATENCY:0][IDX_W-1:0] idx_pipe;

    // Flat view: element [half][row] sits at half*NUM_ROWS+row, i.e. the fetch index.
    logic [2*NUM_ROWS-1:0][RGB_RES-1:0] col_flat;
    assign column_data = col_flat;

    logic start, fetch_last, drain_done, handshake;
    assign start      = (state == IDLE) && !tvalid && (theta_tick || pending);
    assign fetch_last = (state == FETCH) && (fetch_cnt == IDX_W'(2*NUM_ROWS-1));
    assign drain_done = (state == DRAIN) && (drain_cnt == DR_W'(BRAM_LATENCY));
    assign handshake  = tvalid && tready;

    assign theta_inc = (theta_cnt == TH_W'(ROTATIONAL_RES-1)) ? '0 : theta_cnt + TH_W'(1);
    assign base_addr = ADDR_W'(theta) * ADDR_W'(2*NUM_ROWS);

`ifdef COLUMN_SRC_TEST_PATTERN_EN
    logic [31:0] pat_sum;
    always_comb begin
        pat_sum = 32'(theta) + 32'(idx_pipe[BRAM_LATENCY]);
        pix     = pat_sum[RGB_RES-1:0];
    end
`else
    assign pix = bram_data;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = FETCH;
            FETCH:   if (fetch_last) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = VALID;
            VALID:   if (handshake)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            theta_cnt   <= '0;
            theta       <= '0;
            pending     <= 1'b0;
            missed_tick <= 1'b0;
            fetch_cnt   <= '0;
            drain_cnt   <= '0;
            bram_addr   <= '0;
            vld_pipe    <= '0;
            idx_pipe    <= '0;
            col_flat    <= '0;
            tvalid      <= 1'b0;
        end else begin
            // index_in on a starting edge makes this fetch slice 0 and the next one slice 1
            if (start) begin
                theta     <= index_in ? '0 : theta_cnt;
                theta_cnt <= index_in ? TH_W'(1) : theta_inc;
            end else if (index_in) begin
                theta_cnt <= '0;
            end

            // One-deep tick buffer. If a pending fetch starts on the same edge
            // as a live tick, the live tick takes the pending slot.
            if (start) begin
                pending <= pending && theta_tick;
            end else if (theta_tick) begin
                if (pending) missed_tick <= 1'b1;
                else         pending     <= 1'b1;
            end

            if (start)               fetch_cnt <= '0;
            else if (state == FETCH) fetch_cnt <= fetch_cnt + IDX_W'(1);

            if (state == FETCH) bram_addr <= base_addr + ADDR_W'(fetch_cnt);

            drain_cnt <= (state == DRAIN) ? drain_cnt + DR_W'(1) : '0;

            vld_pipe <= {vld_pipe[BRAM_LATENCY-1:0], state == FETCH};
            idx_pipe <= {idx_pipe[BRAM_LATENCY-1:0], fetch_cnt};

            if (vld_pipe[BRAM_LATENCY]) col_flat[idx_pipe[BRAM_LATENCY]] <= pix;

            if (drain_done)     tvalid <= 1'b1;
            else if (handshake) tvalid <= 1'b0;
        end
    end
endmodule

// File: doc/column_stream_source.md
# column_stream_source

Producer for the HUB75 column driver's valid/ready column interface. It reads one angular slice of the voxel image from a synchronous BRAM on each `theta_tick`, assembles both half-panel columns into a single `column_data` word, and holds it on `tvalid` until the driver accepts it with `tready`. It sits between the slice-image BRAM and the HUB75 output stage, and it also tracks the current rotational position (theta).

## Interface
- `ROTATIONAL_RES`, 1024, angular slices per revolution
- `NUM_ROWS`, 64, pixels per half-column
- `RGB_RES`, 9, bits per pixel (3 per colour)
- `BRAM_LATENCY`, 2, cycles from `bram_addr` to valid `bram_data`

Ports:
- `clk_in` in 1: system clock
- `rst_in` in 1: synchronous, active-high reset
- `theta_tick` in 1: one-cycle pulse; advance to the next slice
- `index_in` in 1: one-cycle pulse from the hall sensor; next fetch is slice 0
- `bram_addr` out $clog2(ROTATIONAL_RES*2*NUM_ROWS): read address
- `bram_data` in RGB_RES: read data, valid BRAM_LATENCY cycles after `bram_addr`
- `column_data` out [1:0][NUM_ROWS-1:0][RGB_RES-1:0]: assembled column pair
- `theta` out $clog2(ROTATIONAL_RES): slice index of the current or most recent `column_data`
- `tvalid` out 1: `column_data` valid
- `tready` in 1: consumer accepts
- `missed_tick` out 1: sticky flag; a tick was dropped

## Operation
- States:
  - IDLE → FETCH on a tick (live or pending).
  - FETCH issues 2*NUM_ROWS addresses, one per cycle, then goes to DRAIN.
  - DRAIN waits BRAM_LATENCY cycles for the last returns, then goes to VALID.
  - VALID → IDLE on `tvalid && tready`.
- Address = `fetch_theta*2*NUM_ROWS + half*NUM_ROWS + row`.
  - Order: half 0 rows 0..NUM_ROWS-1, then half 1.
  - Widths are zero-extended; no truncation.
- Return data is written into `column_data[half][row]` through a delay-matched index pipeline of depth BRAM_LATENCY.
- Theta counter:
  - A fetch uses the current counter value and latches it to `theta`.
  - The counter then increments, wrapping ROTATIONAL_RES-1 → 0.
- `index_in` forces the counter to 0.
  - If it coincides with a tick that starts a fetch, that fetch uses slice 0 and the counter becomes 1.
- Tick outside IDLE (or in IDLE while `tvalid` is high) sets `pending` (1 deep).
  - IDLE with `pending` set starts FETCH next cycle and clears `pending`.
  - A tick while `pending` is already set sets `missed_tick`; the tick is dropped.
  - `missed_tick` is cleared only by reset.
- `column_data` and `theta` are stable whenever `tvalid` is high.
- `column_data` is updated only during FETCH/DRAIN.
- `tvalid` never drops without a handshake.
- `bram_addr` holds its last value outside FETCH.

## Timing
- Reset values: `tvalid`=0, `column_data`=0, `theta`=0, `bram_addr`=0, `missed_tick`=0, `pending`=0. Theta counter=0; state=IDLE.
- A reset mid-fetch or mid-VALID aborts immediately.
  - No handshake completes in the reset cycle.
- Tick sampled at edge k, in IDLE:
  - First address at k+1, last address at k+2*NUM_ROWS.
  - `tvalid` high from k+2*NUM_ROWS+BRAM_LATENCY+1 (131 cycles at defaults).
- Handshake at edge h: `tvalid` low at h+1.
  - A tick sampled at edge h is treated as pending.
  - FETCH starts at h+2.
- `tready` is ignored when `tvalid` is low.
  - A consumer may hold `tready` high constantly.

## Configuration
- `COLUMN_SRC_TEST_PATTERN_EN`:
  - When defined, `bram_data` is ignored.
  - The captured pixel is `(fetch_theta + half*NUM_ROWS + row) mod 2**RGB_RES`.
  - It passes through the same BRAM_LATENCY delay line, so all timing is identical.
  - `bram_addr` still toggles.
- Undefined: pixels come from `bram_data`.

## Test plan
- Reset, then tick at cycle 10 with `tready`=1 and the BRAM model returning addr mod 512:
  - `tvalid` rises at cycle 141.
  - `column_data[1][5]` = 69.
  - `theta`=0.
  - `tvalid` falls at cycle 142.
- Hold `tready`=0 for 50 cycles after `tvalid` rises:
  - `column_data` and `theta` stay constant.
  - Release `tready` → exactly one handshake.
- Wrap: 1025 ticks spaced 200 cycles apart:
  - `theta` sequence 0..1023, then 0.
  - Slice-1023 addresses top out at 131071.
- Pending and missed ticks:
  - Second tick 20 cycles into FETCH → second transfer begins 2 cycles after the first handshake; `missed_tick`=0.
  - Third tick in the same window → `missed_tick`=1, held until reset.
- `index_in` at theta counter=37, coincident with a tick → fetched `theta`=0; next tick fetches `theta`=1.
- `COLUMN_SRC_TEST_PATTERN_EN` defined, tick with theta=3 → `column_data[1][63]` = 130; same 131-cycle latency.
